// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states,
// opcode/funct constants, ALUOp codes, mux select encodings and the
// control word passed from the output decoder to the top.
package mips_mc_pkg;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_R_WB     = 4'd4,
      S_EXEC_I   = 4'd5,
      S_I_WB     = 4'd6,
      S_MEM_ADDR = 4'd7,
      S_MEM_RD   = 4'd8,
      S_MEM_WB   = 4'd9,
      S_MEM_WR   = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12,
      S_JR       = 4'd13,
      S_JAL      = 4'd14,
      S_TRAP     = 4'd15
   } state_t;

   // Opcodes (instruction[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // Function codes (instruction[5:0]) with special control treatment
   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_JR  = 6'h08;

   // ALUOp codes
   localparam logic [2:0] ALUOP_NOP   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b011;
   localparam logic [2:0] ALUOP_ADD   = 3'b100;
   localparam logic [2:0] ALUOP_OR    = 3'b101;
   localparam logic [2:0] ALUOP_LUI   = 3'b110;
   localparam logic [2:0] ALUOP_RTYPE = 3'b111;

   // RegDst select
   localparam logic [1:0] REGDST_RT = 2'b00;
   localparam logic [1:0] REGDST_RD = 2'b01;
   localparam logic [1:0] REGDST_RA = 2'b10;

   // MemtoReg select
   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;

   // PCSource select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_RS     = 2'b11;

   // ALUSrcB select
   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // Per-cycle control word
   typedef struct packed {
      logic       mem_req;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       shamt_sel;
      logic [2:0] alu_op;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic       instr_done;
   } ctrl_t;

   // Instruction class used for DECODE dispatch
   typedef enum logic [2:0] {
      CL_RTYPE,
      CL_JR,
      CL_IMM,
      CL_MEM,
      CL_BRANCH,
      CL_JUMP,
      CL_JAL,
      CL_ILLEGAL
   } op_class_t;

   function automatic op_class_t classify(input logic [5:0] op, input logic [5:0] fn);
      op_class_t cl;
      case (op)
         OP_RTYPE:               cl = (fn == FN_JR) ? CL_JR : CL_RTYPE;
         OP_ADDI, OP_ORI, OP_LUI: cl = CL_IMM;
         OP_LW, OP_SW:           cl = CL_MEM;
         OP_BEQ, OP_BNE:         cl = CL_BRANCH;
         OP_J:                   cl = CL_JUMP;
         OP_JAL:                 cl = CL_JAL;
         default:                cl = CL_ILLEGAL;
      endcase
      return cl;
   endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-word decoder: maps the current FSM state (plus the
// Mealy inputs OP, Function, Zero, mem_ready) to every datapath strobe/select.
module mc_output_decode
   import mips_mc_pkg::*;
#(
   parameter bit TRAP_EN = 1'b1
) (
   input  state_t     state_i,
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output ctrl_t      ctrl_o
);

   // Control word for the current state; everything defaults to 0 (IDLE/TRAP)
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_req   = 1'b1;
            ctrl_o.iord      = 1'b0;
            ctrl_o.alu_src_a = 1'b0;
            ctrl_o.alu_src_b = SRCB_FOUR;
            ctrl_o.alu_op    = ALUOP_ADD;
            ctrl_o.pc_source = PCSRC_ALU;
            ctrl_o.ir_write  = mem_ready_i;
            ctrl_o.pc_write  = mem_ready_i;
         end
         S_DECODE: begin
            ctrl_o.alu_src_a = 1'b0;
            ctrl_o.alu_src_b = SRCB_IMM_SH2;
            ctrl_o.alu_op    = ALUOP_ADD;
            // Without trapping, an undefined opcode retires here as a NOP
            if (!TRAP_EN && (classify(op_i, funct_i) == CL_ILLEGAL))
               ctrl_o.instr_done = 1'b1;
         end
         S_EXEC_R: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_RT;
            ctrl_o.alu_op    = ALUOP_RTYPE;
            ctrl_o.shamt_sel = (funct_i == FN_SLL) || (funct_i == FN_SRL);
         end
         S_R_WB: begin
            ctrl_o.reg_dst    = REGDST_RD;
            ctrl_o.mem_to_reg = M2R_ALUOUT;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_EXEC_I: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
            case (op_i)
               OP_ORI:  ctrl_o.alu_op = ALUOP_OR;
               OP_LUI:  ctrl_o.alu_op = ALUOP_LUI;
               default: ctrl_o.alu_op = ALUOP_ADD;
            endcase
         end
         S_I_WB: begin
            ctrl_o.reg_dst    = REGDST_RT;
            ctrl_o.mem_to_reg = M2R_ALUOUT;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_MEM_ADDR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         S_MEM_RD: begin
            ctrl_o.mem_req = 1'b1;
            ctrl_o.iord    = 1'b1;
         end
         S_MEM_WB: begin
            ctrl_o.reg_dst    = REGDST_RT;
            ctrl_o.mem_to_reg = M2R_MDR;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_MEM_WR: begin
            ctrl_o.mem_req    = 1'b1;
            ctrl_o.iord       = 1'b1;
            ctrl_o.mem_write  = 1'b1;
            ctrl_o.instr_done = mem_ready_i;
         end
         S_BRANCH: begin
            ctrl_o.alu_src_a  = 1'b1;
            ctrl_o.alu_src_b  = SRCB_RT;
            ctrl_o.alu_op     = ALUOP_SUB;
            ctrl_o.pc_source  = PCSRC_ALUOUT;
            ctrl_o.pc_write   = (op_i == OP_BEQ) ? zero_i : ~zero_i;
            ctrl_o.instr_done = 1'b1;
         end
         S_JUMP: begin
            ctrl_o.pc_source  = PCSRC_JUMP;
            ctrl_o.pc_write   = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_JR: begin
            ctrl_o.pc_source  = PCSRC_RS;
            ctrl_o.pc_write   = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_JAL: begin
            ctrl_o.pc_source  = PCSRC_JUMP;
            ctrl_o.pc_write   = 1'b1;
            ctrl_o.reg_dst    = REGDST_RA;
            ctrl_o.mem_to_reg = M2R_PC;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, next-state dispatch,
// retired-instruction counter and sticky illegal-opcode flag. Output
// strobes come from mc_output_decode and are forced low while reset is high.
module multicycle_control
   import mips_mc_pkg::*;
#(
   parameter int unsigned ALUOP_W = 3,
   parameter int unsigned COUNT_W = 32,
   parameter bit          TRAP_EN = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic [5:0]         OP,
   input  logic [5:0]         Function,
   input  logic               Zero,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               IorD,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic [1:0]         PCSource,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic               ShamtSelector,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [1:0]         RegDst,
   output logic [1:0]         MemtoReg,
   output logic               RegWrite,
   output logic               instr_done,
   output logic               illegal_op,
   output logic [COUNT_W-1:0] instr_count
);

   state_t               state_q, state_d;
   logic [COUNT_W-1:0]   count_q, count_d;
   logic                 illegal_q, illegal_d;
   ctrl_t                ctrl_raw, ctrl;
   state_t               boundary;

   mc_output_decode #(
      .TRAP_EN(TRAP_EN)
   ) u_decode (
      .state_i    (state_q),
      .op_i       (OP),
      .funct_i    (Function),
      .zero_i     (Zero),
      .mem_ready_i(mem_ready),
      .ctrl_o     (ctrl_raw)
   );

   // Strobes drop the instant reset rises, independent of the clock
   assign ctrl = reset ? '0 : ctrl_raw;

   assign mem_req       = ctrl.mem_req;
   assign IorD          = ctrl.iord;
   assign MemWrite      = ctrl.mem_write;
   assign IRWrite       = ctrl.ir_write;
   assign PCWrite       = ctrl.pc_write;
   assign PCSource      = ctrl.pc_source;
   assign ALUSrcA       = ctrl.alu_src_a;
   assign ALUSrcB       = ctrl.alu_src_b;
   assign ShamtSelector = ctrl.shamt_sel;
   assign ALUOp         = ALUOP_W'(ctrl.alu_op);
   assign RegDst        = ctrl.reg_dst;
   assign MemtoReg      = ctrl.mem_to_reg;
   assign RegWrite      = ctrl.reg_write;
   assign instr_done    = ctrl.instr_done;
   assign illegal_op    = illegal_q;
   assign instr_count   = count_q;

   // run is only consulted here, at the end of an instruction
   assign boundary = run ? S_FETCH : S_IDLE;

   // Next-state, counter and trap-flag logic
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      illegal_d = illegal_q;
      case (state_q)
         S_IDLE:     state_d = run ? S_FETCH : S_IDLE;
         S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (classify(OP, Function))
               CL_RTYPE:  state_d = S_EXEC_R;
               CL_JR:     state_d = S_JR;
               CL_IMM:    state_d = S_EXEC_I;
               CL_MEM:    state_d = S_MEM_ADDR;
               CL_BRANCH: state_d = S_BRANCH;
               CL_JUMP:   state_d = S_JUMP;
               CL_JAL:    state_d = S_JAL;
               default:   state_d = TRAP_EN ? S_TRAP : boundary;
            endcase
         end
         S_EXEC_R:   state_d = S_R_WB;
         S_EXEC_I:   state_d = S_I_WB;
         S_MEM_ADDR: state_d = (OP == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
         S_MEM_WR:   state_d = mem_ready ? boundary : S_MEM_WR;
         S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_JR, S_JAL:
                     state_d = boundary;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_IDLE;
      endcase
      if (ctrl_raw.instr_done)
         count_d = count_q + COUNT_W'(1);
      if (state_d == S_TRAP)
         illegal_d = 1'b1;
   end

   // State, counter and sticky flag registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         illegal_q <= illegal_d;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction pushes its
// expected retirement record to a scoreboard; the record is popped and
// compared when instr_done is seen. A 3-bit counter exposes the wrap.
module tb_multicycle_control;

   localparam int unsigned CW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          run;
   logic [5:0]    OP;
   logic [5:0]    Function;
   logic          Zero;
   logic          mem_ready;
   logic          mem_req, IorD, MemWrite, IRWrite, PCWrite;
   logic [1:0]    PCSource;
   logic          ALUSrcA;
   logic [1:0]    ALUSrcB;
   logic          ShamtSelector;
   logic [2:0]    ALUOp;
   logic [1:0]    RegDst, MemtoReg;
   logic          RegWrite, instr_done, illegal_op;
   logic [CW-1:0] instr_count;

   always #5 clk = ~clk;

   multicycle_control #(
      .ALUOP_W(3),
      .COUNT_W(CW),
      .TRAP_EN(1'b1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .run          (run),
      .OP           (OP),
      .Function     (Function),
      .Zero         (Zero),
      .mem_ready    (mem_ready),
      .mem_req      (mem_req),
      .IorD         (IorD),
      .MemWrite     (MemWrite),
      .IRWrite      (IRWrite),
      .PCWrite      (PCWrite),
      .PCSource     (PCSource),
      .ALUSrcA      (ALUSrcA),
      .ALUSrcB      (ALUSrcB),
      .ShamtSelector(ShamtSelector),
      .ALUOp        (ALUOp),
      .RegDst       (RegDst),
      .MemtoReg     (MemtoReg),
      .RegWrite     (RegWrite),
      .instr_done   (instr_done),
      .illegal_op   (illegal_op),
      .instr_count  (instr_count)
   );

   typedef struct {
      int unsigned cycles;   // FETCH..final state inclusive
      int unsigned data;     // cycles with a data-phase memory request
      logic [2:0]  aluop3;   // third-cycle ALU controls
      logic        srca3;
      logic [1:0]  srcb3;
      logic        shamt3;
      logic        pcw;      // final-cycle controls
      logic [1:0]  pcsrc;
      logic [1:0]  regdst;
      logic [1:0]  m2r;
      logic        regw;
      logic        memw;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned model_count = 0;
   string       cur = "init";

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s/%s: got %0h expected %0h", cur, tag, got, want);
      end
   endtask

   task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int unsigned stall,
                            input int unsigned drop_run_at, input int unsigned abort_at,
                            input exp_t e);
      int unsigned cyc = 0, data_cyc = 0, stall_cyc = 0, stall_left = stall, guard = 0;
      bit done = 0;
      bit hold;
      exp_t x;
      cur = nm;
      OP = op; Function = fn; Zero = z;
      if (abort_at == 0) sb.push_back(e);
      while (!done && guard < 64) begin
         @(negedge clk);
         guard++;
         hold = mem_req && IorD && (stall_left > 0);
         mem_ready = !hold;
         if (hold) stall_left--;
         #1;
         if (cyc == 0 && mem_req && !IorD) begin
            cyc = 1;
            check("count_start", 32'(instr_count), model_count % 8);
         end else if (cyc > 0) begin
            cyc++;
         end
         if (cyc > 0) begin
            if (mem_req && IorD) data_cyc++;
            if (mem_req && IorD && !mem_ready) stall_cyc++;
            if (cyc == 1) begin
               check("f_aluop", 32'(ALUOp), 32'h4);
               check("f_srcb", 32'(ALUSrcB), 32'h1);
               check("f_irw_pcw", {30'd0, IRWrite, PCWrite}, 32'h3);
            end
            if (cyc == 2) begin
               check("d_ctl", {27'd0, ALUOp, ALUSrcA, mem_req}, {27'd0, 3'b100, 1'b0, 1'b0});
               check("d_srcb", 32'(ALUSrcB), 32'h3);
            end
            if (cyc == 3) begin
               check("c3_aluop", 32'(ALUOp), 32'(e.aluop3));
               check("c3_src", {28'd0, ALUSrcA, ALUSrcB, ShamtSelector},
                     {28'd0, e.srca3, e.srcb3, e.shamt3});
            end
            if (cyc == drop_run_at) run = 1'b0;
            if (cyc == abort_at) begin
               check("pre_abort_memw", {30'd0, MemWrite, mem_req}, 32'h3);
               reset = 1'b1;
               #1;
               check("abort_strobes", {29'd0, MemWrite, mem_req, IorD}, 32'h0);
               done = 1;
            end else if (instr_done) begin
               done = 1;
               check("sb_size", sb.size(), 1);
               if (sb.size() > 0) begin
                  x = sb.pop_front();
                  check("cycles", cyc, x.cycles);
                  check("data_cyc", data_cyc, x.data);
                  check("stall_cyc", stall_cyc, stall);
                  check("pc", {29'd0, PCWrite, PCSource}, {29'd0, x.pcw, x.pcsrc});
                  check("wb", {27'd0, RegDst, MemtoReg, RegWrite},
                        {27'd0, x.regdst, x.m2r, x.regw});
                  check("memw", 32'(MemWrite), 32'(x.memw));
                  model_count++;
               end
            end
         end
      end
      if (abort_at == 0) check("done_seen", 32'(done), 1);
      mem_ready = 1'b1;
   endtask

   initial begin
      bit found;
      reset = 1'b1; run = 1'b0; OP = '0; Function = '0; Zero = 1'b0; mem_ready = 1'b1;
      @(negedge clk); #1;
      run = 1'b1;
      #1;
      check("rst_strobes", {26'd0, mem_req, IRWrite, PCWrite, RegWrite, MemWrite, instr_done}, 32'h0);
      check("rst_cnt_ill", {28'd0, instr_count, illegal_op}, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      //                                  cyc data alu   A  B     sh pcw pcsrc  rdst   m2r    rw mw
      run_instr("add",  6'h00, 6'h20, 0, 0, 0, 0, exp_t'{4, 0, 3'b111, 1, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00, 1, 0});
      run_instr("sll",  6'h00, 6'h00, 0, 0, 0, 0, exp_t'{4, 0, 3'b111, 1, 2'b00, 1, 0, 2'b00, 2'b01, 2'b00, 1, 0});
      run_instr("srl",  6'h00, 6'h02, 0, 0, 0, 0, exp_t'{4, 0, 3'b111, 1, 2'b00, 1, 0, 2'b00, 2'b01, 2'b00, 1, 0});
      run_instr("jr",   6'h00, 6'h08, 0, 0, 0, 0, exp_t'{3, 0, 3'b000, 0, 2'b00, 0, 1, 2'b11, 2'b00, 2'b00, 0, 0});
      run_instr("addi", 6'h08, 6'h15, 0, 0, 0, 0, exp_t'{4, 0, 3'b100, 1, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0});
      run_instr("ori",  6'h0D, 6'h00, 0, 0, 0, 0, exp_t'{4, 0, 3'b101, 1, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0});
      run_instr("lui",  6'h0F, 6'h02, 0, 0, 0, 0, exp_t'{4, 0, 3'b110, 1, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0});
      run_instr("lw",   6'h23, 6'h00, 0, 3, 0, 0, exp_t'{8, 4, 3'b100, 1, 2'b10, 0, 0, 2'b00, 2'b00, 2'b01, 1, 0});
      run_instr("sw",   6'h2B, 6'h00, 0, 0, 0, 0, exp_t'{4, 1, 3'b100, 1, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1});
      run_instr("beq1", 6'h04, 6'h00, 1, 0, 0, 0, exp_t'{3, 0, 3'b011, 1, 2'b00, 0, 1, 2'b01, 2'b00, 2'b00, 0, 0});
      run_instr("bne1", 6'h05, 6'h00, 1, 0, 0, 0, exp_t'{3, 0, 3'b011, 1, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0});
      run_instr("beq0", 6'h04, 6'h00, 0, 0, 0, 0, exp_t'{3, 0, 3'b011, 1, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0});
      run_instr("bne0", 6'h05, 6'h00, 0, 0, 0, 0, exp_t'{3, 0, 3'b011, 1, 2'b00, 0, 1, 2'b01, 2'b00, 2'b00, 0, 0});
      run_instr("j",    6'h02, 6'h00, 0, 0, 0, 0, exp_t'{3, 0, 3'b000, 0, 2'b00, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0});
      run_instr("jal",  6'h03, 6'h00, 0, 0, 0, 0, exp_t'{3, 0, 3'b000, 0, 2'b00, 0, 1, 2'b10, 2'b10, 2'b10, 1, 0});

      // run drops during MEM_ADDR: the store still completes, then IDLE
      run_instr("sw_halt", 6'h2B, 6'h00, 0, 2, 3, 0, exp_t'{6, 3, 3'b100, 1, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1});
      cur = "halted";
      repeat (3) begin
         @(negedge clk); #1;
         check("idle_strobes", {27'd0, mem_req, IRWrite, PCWrite, RegWrite, instr_done}, 32'h0);
         check("idle_count", 32'(instr_count), model_count % 8);
      end
      run = 1'b1;

      // Undefined opcode traps; flag sticky, count frozen; reset clears both
      cur = "trap";
      OP = 6'h3F; Function = 6'h00;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk); #1;
         if (mem_req && !IorD) found = 1;
      end
      check("fetch_seen", 32'(found), 1);
      @(negedge clk); #1;
      check("ill_pre", {30'd0, illegal_op, instr_done}, 32'h0);
      repeat (4) begin
         @(negedge clk); #1;
         check("ill_set", 32'(illegal_op), 1);
         check("trap_strobes", {26'd0, mem_req, IRWrite, PCWrite, RegWrite, MemWrite, instr_done}, 32'h0);
         check("trap_count", 32'(instr_count), model_count % 8);
      end
      reset = 1'b1;
      #1;
      check("trap_rst", {28'd0, instr_count, illegal_op}, 32'h0);
      model_count = 0;
      @(negedge clk);
      reset = 1'b0;

      run_instr("add2", 6'h00, 6'h21, 0, 0, 0, 0, exp_t'{4, 0, 3'b111, 1, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00, 1, 0});
      // Reset while a store waits for memory: strobes must drop at once
      run_instr("sw_abort", 6'h2B, 6'h00, 0, 5, 0, 5, exp_t'{0, 0, 3'b100, 1, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1});
      model_count = 0;
      check("abort_cnt", {28'd0, instr_count, illegal_op}, 32'h0);
      check("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
